cdb_arbiter: RTL and testbench

- Arbitrates the single result broadcast bus (flag/map/reg/val) among several completion sources: EXE ALU results, LSQ load returns, and future multi-cycle units.
- Each source pushes results into a small per-source FIFO. A round-robin arbiter pops one head per cycle into registered broadcast outputs.
- Broadcast outputs feed the issue queue wakeup, the physical register file write and the LSQ.
- Replaces the direct EXE-driven broadcast so loads and ALU ops can complete in the same cycle without either being lost.

---
 rtl/cdb_pkg.sv | 46 ++++
 rtl/cdb_arbiter_if.sv | 34 +++
 rtl/cdb_fifo.sv | 97 +++++++++
 rtl/cdb_arbiter.sv | 106 ++++++++++
 tb/tb_cdb_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// Shared definitions for the result broadcast (CDB) arbiter.
//   MAP_W / REG_W / DATA_W : physical map, architectural register and value widths
//   cdb_entry_t            : one completed result {map, areg, val}
//   rr_pick()              : round-robin pick of the first requester at or after ptr
package cdb_pkg;

  localparam int MAP_W    = 6;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  // Largest requester count rr_pick() can scan; the request vector is padded to this.
  localparam int RR_MAX   = 8;
  localparam int RR_IDX_W = 3;

  // 'reg' is a keyword, so the architectural register field is named areg.
  typedef struct packed {
    logic [MAP_W-1:0]  map;
    logic [REG_W-1:0]  areg;
    logic [DATA_W-1:0] val;
  } cdb_entry_t;

  // Returns the first set bit of req_vec at or after ptr, wrapping modulo n_req.
  // Returns 0 when nothing is requested; the caller qualifies with |req_vec.
  function automatic int rr_pick(input logic [RR_MAX-1:0] req_vec,
                                 input int ptr, input int n_req);
    int   idx;
    int   pick;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      if (i < n_req) begin
        idx = ptr + i;
        // ptr < n_req and i < n_req, so one subtraction is enough to wrap.
        if (idx >= n_req) begin
          idx = idx - n_req;
        end
        if (!found && req_vec[idx[RR_IDX_W-1:0]]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester and broadcast bus bundle of the CDB arbiter.
//   req_valid/req_ready     : per-requester handshake
//   req_map/req_reg/req_val : flattened per-requester payload, requester i at slice i
//   broadcast_*             : registered single-result broadcast
// master = requester/consumer side, slave = arbiter side.
interface cdb_arbiter_if import cdb_pkg::*; #(parameter int N_REQ = 2);

  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*MAP_W-1:0]  req_map;
  logic [N_REQ*REG_W-1:0]  req_reg;
  logic [N_REQ*DATA_W-1:0] req_val;

  logic                    broadcast_flag;
  logic [MAP_W-1:0]        broadcast_map;
  logic [REG_W-1:0]        broadcast_reg;
  logic [DATA_W-1:0]       broadcast_val;
  logic [SRC_W-1:0]        broadcast_src;

  modport master (
    output req_valid, req_map, req_reg, req_val,
    input  req_ready,
    input  broadcast_flag, broadcast_map, broadcast_reg, broadcast_val, broadcast_src
  );

  modport slave (
    input  req_valid, req_map, req_reg, req_val,
    output req_ready,
    output broadcast_flag, broadcast_map, broadcast_reg, broadcast_val, broadcast_src
  );

endinterface

// File: rtl/cdb_fifo.sv
// Small per-requester result FIFO.
//   CLK/RESET : clock, synchronous active-high reset
//   clr       : synchronous clear (flush); drops any push or pop in the same cycle
//   push/din  : write at tail (ignored when full)
//   pop/dout  : dout is the head; pop advances it (ignored when empty)
//   count     : occupancy 0..DEPTH, full/empty derived from it
module cdb_fifo import cdb_pkg::*; #(
  parameter int  DEPTH = 2,
  parameter type T     = cdb_entry_t,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clr,
  input  logic             push,
  input  T                 din,
  input  logic             pop,
  output T                 dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Explicit wrap keeps DEPTH == 1 correct; for powers of two it equals the natural wrap.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + 1'b1;
    end
  endfunction

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign dout      = mem_q[head_q];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Next-state pointers and occupancy; push+pop together leaves count unchanged.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push_s) begin
        tail_d = ptr_inc(tail_q);
      end else begin
        tail_d = tail_q;
      end
      if (do_pop_s) begin
        head_d = ptr_inc(head_q);
      end else begin
        head_d = head_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage; contents are don't-care while count says the slot is empty.
  always_ff @(posedge CLK) begin
    if (do_push_s && !clr && !RESET) begin
      mem_q[tail_q] <= din;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Result broadcast (CDB) arbiter: each requester pushes completed results into
// its own FIFO; a round-robin arbiter pops one head per cycle into registered
// broadcast outputs.
//   CLK   : clock
//   RESET : synchronous active-high reset (priority over flush, push and pop)
//   flush : clears every FIFO, discards same-cycle pushes, no grant that cycle
//   bus   : requester handshakes and broadcast outputs (cdb_arbiter_if.slave)
module cdb_arbiter import cdb_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);

  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  cdb_entry_t        din_s   [N_REQ];
  cdb_entry_t        dout_s  [N_REQ];
  logic [CNT_W-1:0]  count_s [N_REQ];
  logic [N_REQ-1:0]  full_s, empty_s, push_s, pop_s, ready_s;
  logic [RR_MAX-1:0] cand_s;
  logic              grant_valid_s;
  logic [SRC_W-1:0]  grant_idx_s;
  cdb_entry_t        grant_entry_s;

  logic              flag_q, flag_d;
  cdb_entry_t        bcast_q, bcast_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [SRC_W-1:0]  rr_q, rr_d;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign din_s[gi]   = {bus.req_map[gi*MAP_W +: MAP_W],
                          bus.req_reg[gi*REG_W +: REG_W],
                          bus.req_val[gi*DATA_W +: DATA_W]};
    // Ready from registered occupancy only: a full FIFO stays not-ready even if popped now.
    assign ready_s[gi] = (count_s[gi] != CNT_W'(DEPTH));
    assign push_s[gi]  = bus.req_valid[gi] & ~full_s[gi] & ~flush;
    assign pop_s[gi]   = grant_valid_s & (grant_idx_s == SRC_W'(gi));

    cdb_fifo #(.DEPTH(DEPTH), .T(cdb_entry_t)) u_fifo (
      .CLK   (CLK),
      .RESET (RESET),
      .clr   (flush),
      .push  (push_s[gi]),
      .din   (din_s[gi]),
      .pop   (pop_s[gi]),
      .dout  (dout_s[gi]),
      .count (count_s[gi]),
      .full  (full_s[gi]),
      .empty (empty_s[gi])
    );
  end

  assign bus.req_ready = ready_s;

  // Round-robin grant among non-empty FIFOs; suppressed during flush.
  always_comb begin
    cand_s               = '0;
    cand_s[N_REQ-1:0]    = ~empty_s;
    grant_valid_s        = (|cand_s) & ~flush;
    grant_idx_s          = SRC_W'(rr_pick(cand_s, int'(rr_q), N_REQ));
    grant_entry_s        = dout_s[grant_idx_s];
  end

  // Broadcast and pointer next-state: payload/src/rr hold when nothing is granted.
  always_comb begin
    flag_d  = 1'b0;
    bcast_d = bcast_q;
    src_d   = src_q;
    rr_d    = rr_q;
    if (grant_valid_s) begin
      flag_d  = 1'b1;
      bcast_d = grant_entry_s;
      src_d   = grant_idx_s;
      rr_d    = (grant_idx_s == SRC_W'(N_REQ - 1)) ? '0 : grant_idx_s + 1'b1;
    end else begin
      flag_d  = 1'b0;
    end
  end

  // Broadcast output and round-robin pointer registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      flag_q  <= 1'b0;
      bcast_q <= '0;
      src_q   <= '0;
      rr_q    <= '0;
    end else begin
      flag_q  <= flag_d;
      bcast_q <= bcast_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.broadcast_flag = flag_q;
  assign bus.broadcast_map  = bcast_q.map;
  assign bus.broadcast_reg  = bcast_q.areg;
  assign bus.broadcast_val  = bcast_q.val;
  assign bus.broadcast_src  = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (N_REQ=2, DEPTH=2). A reference model
// keeps per-requester queues of accepted entries and a round-robin pointer;
// every cycle the DUT broadcast and ready outputs are compared with it, and
// directed checks pin the scenario-specific values.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N_REQ = 2;
  localparam int DEPTH = 2;

  logic CLK = 1'b0;
  logic RESET;
  logic flush;

  always #5 CLK = ~CLK;

  cdb_arbiter_if #(.N_REQ(N_REQ)) bus ();

  cdb_arbiter #(.N_REQ(N_REQ), .DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .flush (flush),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  cdb_entry_t pend0[$];
  cdb_entry_t pend1[$];
  cdb_entry_t mq0[$];
  cdb_entry_t mq1[$];
  int         rr_m;
  logic       exp_flag;
  logic [0:0] exp_src;
  cdb_entry_t exp_e;
  logic       acc0, acc1;

  int seen0, seen1, last_src, alt_bad, ready_low1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit tb_idle();
    return (pend0.size() == 0) && (pend1.size() == 0) && (mq0.size() == 0) && (mq1.size() == 0);
  endfunction

  task automatic drive();
    cdb_entry_t e0, e1;
    e0 = (pend0.size() > 0) ? pend0[0] : '0;
    e1 = (pend1.size() > 0) ? pend1[0] : '0;
    bus.req_valid = {pend1.size() > 0, pend0.size() > 0};
    bus.req_map   = {e1.map, e0.map};
    bus.req_reg   = {e1.areg, e0.areg};
    bus.req_val   = {e1.val, e0.val};
  endtask

  // Reference behaviour at a rising edge, from the inputs driven before it.
  task automatic model_edge();
    int g;
    int idx;
    acc0 = bus.req_valid[0] && (mq0.size() < DEPTH) && !RESET;
    acc1 = bus.req_valid[1] && (mq1.size() < DEPTH) && !RESET;
    if (RESET) begin
      mq0.delete();
      mq1.delete();
      rr_m     = 0;
      exp_flag = 1'b0;
      exp_src  = 1'b0;
      exp_e    = '0;
    end else if (flush) begin
      mq0.delete();
      mq1.delete();
      exp_flag = 1'b0;
    end else begin
      g = -1;
      for (int k = 0; k < N_REQ; k++) begin
        idx = (rr_m + k) % N_REQ;
        if (g < 0 && ((idx == 0 && mq0.size() > 0) || (idx == 1 && mq1.size() > 0))) g = idx;
      end
      exp_flag = (g >= 0);
      if (g == 0) exp_e = mq0.pop_front();
      if (g == 1) exp_e = mq1.pop_front();
      if (g >= 0) begin
        exp_src = 1'(g);
        rr_m    = (g + 1) % N_REQ;
      end
      if (acc0) mq0.push_back(pend0[0]);
      if (acc1) mq1.push_back(pend1[0]);
    end
  endtask

  task automatic step();
    drive();
    @(posedge CLK);
    model_edge();
    #1;
    if (acc0) void'(pend0.pop_front());
    if (acc1) void'(pend1.pop_front());
    check("bcast_flag", 64'(bus.broadcast_flag), 64'(exp_flag));
    check("bcast_payload",
          64'({bus.broadcast_src, bus.broadcast_map, bus.broadcast_reg, bus.broadcast_val}),
          64'({exp_src, exp_e}));
    check("req_ready", 64'(bus.req_ready), 64'({mq1.size() < DEPTH, mq0.size() < DEPTH}));
    if (!bus.req_ready[1]) ready_low1++;
    if (bus.broadcast_flag) begin
      if (bus.broadcast_src == 1'b0) seen0++;
      else seen1++;
      if (last_src == int'(bus.broadcast_src)) alt_bad++;
      last_src = int'(bus.broadcast_src);
    end
  endtask

  task automatic do_reset();
    pend0.delete();
    pend1.delete();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  task automatic clear_stats();
    seen0 = 0; seen1 = 0; last_src = -1; alt_bad = 0; ready_low1 = 0;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (!tb_idle() && guard < 40) begin
      step();
      guard++;
    end
    check(tag, 64'(tb_idle()), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; flush = 1'b0;
    rr_m = 0; exp_flag = 1'b0; exp_src = 1'b0; exp_e = '0;
    clear_stats();
    step();
    step();
    RESET = 1'b0;
    check("rst_flag",  64'(bus.broadcast_flag), 64'd0);
    check("rst_val",   64'(bus.broadcast_val),  64'd0);
    check("rst_src",   64'(bus.broadcast_src),  64'd0);
    check("rst_ready", 64'(bus.req_ready),      64'h3);

    // 1: single push, broadcast one cycle after acceptance
    pend0.push_back('{map: 6'h05, areg: 5'd3, val: 32'hDEADBEEF});
    step();
    check("t1_no_bcast_at_accept", 64'(bus.broadcast_flag), 64'd0);
    step();
    check("t1_flag", 64'(bus.broadcast_flag), 64'd1);
    check("t1_val",  64'(bus.broadcast_val),  64'hDEADBEEF);
    check("t1_map",  64'(bus.broadcast_map),  64'h05);
    check("t1_reg",  64'(bus.broadcast_reg),  64'd3);
    check("t1_src",  64'(bus.broadcast_src),  64'd0);
    step();
    check("t1_flag_low", 64'(bus.broadcast_flag), 64'd0);

    // 2: simultaneous pushes from a fresh pointer
    do_reset();
    pend0.push_back('{map: 6'h01, areg: 5'd1, val: 32'h11});
    pend1.push_back('{map: 6'h02, areg: 5'd2, val: 32'h22});
    step();
    step();
    check("t2_first_val", 64'(bus.broadcast_val), 64'h11);
    check("t2_first_src", 64'(bus.broadcast_src), 64'd0);
    step();
    check("t2_second_val", 64'(bus.broadcast_val), 64'h22);
    check("t2_second_src", 64'(bus.broadcast_src), 64'd1);
    step();
    check("t2_flag_low", 64'(bus.broadcast_flag), 64'd0);

    // 3: backpressure, req0 streams while req1 holds three results
    clear_stats();
    for (int k = 0; k < 6; k++) pend0.push_back('{map: 6'(k), areg: 5'(k), val: 32'hA000_0000 + 32'(k)});
    for (int k = 0; k < 3; k++) pend1.push_back('{map: 6'(k + 8), areg: 5'(k + 8), val: 32'hB000_0000 + 32'(k)});
    drain("t3_drained");
    check("t3_req0_count", 64'(seen0), 64'd6);
    check("t3_req1_count", 64'(seen1), 64'd3);
    check("t3_backpressure_seen", 64'(ready_low1 != 0), 64'd1);

    // 4: flush with FIFO0 holding two entries and FIFO1 one
    do_reset();
    for (int k = 0; k < 4; k++) pend0.push_back('{map: 6'h10, areg: 5'd4, val: 32'h4000_0001 + 32'(k)});
    for (int k = 0; k < 2; k++) pend1.push_back('{map: 6'h20, areg: 5'd5, val: 32'h4100_0001 + 32'(k)});
    step();
    step();
    step();
    check("t4_prefill_ready", 64'(bus.req_ready), 64'h2);
    pend1.push_back('{map: 6'h21, areg: 5'd6, val: 32'h4100_0003});
    flush = 1'b1;
    step();
    flush = 1'b0;
    pend0.delete();
    pend1.delete();
    check("t4_flag_after_flush",  64'(bus.broadcast_flag), 64'd0);
    check("t4_ready_after_flush", 64'(bus.req_ready),      64'h3);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_no_flushed_bcast", 64'(bus.broadcast_flag), 64'd0);
    end

    // 5: reset while both FIFOs hold entries and a broadcast is live
    for (int k = 0; k < 3; k++) begin
      pend0.push_back('{map: 6'h30, areg: 5'd7, val: 32'h5000_0000 + 32'(k)});
      pend1.push_back('{map: 6'h31, areg: 5'd8, val: 32'h5100_0000 + 32'(k)});
    end
    step();
    step();
    check("t5_live_before_reset", 64'(bus.broadcast_flag), 64'd1);
    do_reset();
    check("t5_rst_flag", 64'(bus.broadcast_flag), 64'd0);
    check("t5_rst_map",  64'(bus.broadcast_map),  64'd0);
    check("t5_rst_reg",  64'(bus.broadcast_reg),  64'd0);
    check("t5_rst_val",  64'(bus.broadcast_val),  64'd0);
    check("t5_rst_src",  64'(bus.broadcast_src),  64'd0);
    pend1.push_back('{map: 6'h2A, areg: 5'd17, val: 32'hCAFEF00D});
    step();
    step();
    check("t5_post_flag", 64'(bus.broadcast_flag), 64'd1);
    check("t5_post_src",  64'(bus.broadcast_src),  64'd1);
    check("t5_post_val",  64'(bus.broadcast_val),  64'hCAFEF00D);
    step();
    check("t5_post_flag_low", 64'(bus.broadcast_flag), 64'd0);

    // 6: fairness, both requesters continuously valid
    for (int k = 0; k < 10; k++) begin
      pend0.push_back('{map: 6'(k), areg: 5'd9, val: 32'h6000_0000 + 32'(k)});
      pend1.push_back('{map: 6'(k + 16), areg: 5'd10, val: 32'h6100_0000 + 32'(k)});
    end
    step();
    clear_stats();
    for (int k = 0; k < 10; k++) step();
    check("t6_grants_req0", 64'(seen0),   64'd5);
    check("t6_grants_req1", 64'(seen1),   64'd5);
    check("t6_alternation", 64'(alt_bad), 64'd0);
    pend0.delete();
    pend1.delete();
    drain("t6_drained");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
